cache_stats_reader: RTL
=======================

// Module: cache_stats_reader
// PURPOSE
//  Initiator side of the cache performance controller's comm interface.
//  - Gates counting (comm bit 24) while a run is active.
//  - On request, freezes the counters and walks the statistics select map.
//  - Reassembles each 64-bit counter from two 32-bit reads.
//  - Streams {index, value} records to the host/logging path over a valid/ready handshake.
//  Sits between the host control logic and one cache's performance controller
//  (one instance per cache).
// PARAMETERS
//  READ_LATENCY  2  cycles from a comm_o select change until comm_i is valid to sample (1..15)
//  AUTO_REARM    1  1: counting re-enables automatically after a dump if run_i is still high
// PORTS
//  clock_i               in   1   single clock; all state changes on posedge
//  reset_i               in   1   asynchronous, active-high reset
//  run_i                 in   1   host wants counters enabled
//  start_i               in   1   single-cycle pulse: dump all records
//  comm_o                out  32  to controller comm_i: [24]=count enable, [4:0]=select, other bits 0
//  select_data_record_o  out  2   to controller select_data_record; always 2'b00 (statistics page)
//  comm_i                in   32  from controller comm_o (registered read data)
//  data_o                out  64  record value {hi,lo}
//  index_o               out  4   record index 0..9
//  valid_o               out  1   data_o/index_o valid
//  ready_i               in   1   sink accepts when valid_o & ready_i
//  busy_o                out  1   dump in progress (start_i ignored)
//  done_o                out  1   one-cycle pulse after record 9 is accepted
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; counting disabled until run_i is sampled high.
//  Record map, index:selects(lo,hi):
//  - 0:(0,1) hits; 1:(2,3) misses; 2:(4,5) writebacks; 3:(6,7) walltime
//  - 4:(8,9) expired; 5:(10,11) defaulted; 6:(12,13) multi-expired
//  - 7:(16,17) default misses; 8:(18,19) random evictions
//  - 9:(15,-) cache id; hi word forced 0, no hi read issued
//  comm_o[24]: registered; equals run_i only while FSM=IDLE, else 0.
//  FSM states: IDLE, FREEZE, RD_LO, RD_HI, OUT, DONE.
//  IDLE:
//  - start_i=1 -> FREEZE; bit 24 drops on the next edge.
//  - start_i with run_i in the same cycle: start wins.
//  FREEZE: one cycle so the final increment lands -> RD_LO with index 0.
//  RD_LO / RD_HI:
//  - comm_o[4:0] is set to the select on state entry.
//  - A wait counter runs 0..READ_LATENCY; comm_i is sampled into lo/hi when it reaches READ_LATENCY.
//  - Each word therefore costs READ_LATENCY+1 cycles.
//  - RD_LO -> RD_HI, or -> OUT when index=9.
//  OUT: valid_o=1; data_o/index_o are stable until the handshake.
//  - ready_i=0 stalls indefinitely; comm_o is held.
//  - On handshake: index=9 -> DONE, else index+1 -> RD_LO.
//  DONE: done_o=1 for one cycle -> IDLE; comm_o[24]=run_i from the next cycle if AUTO_REARM, else only after run_i falls and rises again.
//  busy_o = (FSM != IDLE); start_i while busy is dropped, not queued.
//  Reset mid-dump: immediate return to IDLE, valid_o=0, no done_o; the partial dump is discarded.
//  Index never exceeds 9; no wrap-around.
// TESTING
//  1. Reset asserted mid-dump (state RD_HI, index 4) -> all outputs 0 on the same cycle; IDLE after release; comm_o[24]=0 until run_i is sampled high.
//  2. run_i=1 for 100 cycles, model counts hits, start_i pulse -> comm_o[24] falls 1 cycle later; 10 records, index 0..9; record 0 = model hits; record 3 = walltime.
//  3. READ_LATENCY=2, ready_i=1 -> record 0 valid 1 (FREEZE) + 2x3 (RD_LO, RD_HI) = 7 cycles after the start_i edge; done_o 1 cycle after record 9 is accepted.
//  4. ready_i low 20 cycles at index 5 -> valid_o held, data_o/index_o/comm_o unchanged; resumes with index 6.
//  5. Model counter 0x0000_0001_FFFF_FFFF -> data_o=0x00000001FFFFFFFF; id record: data_o[63:32]=0 and select 15 issued exactly once.
//  6. start_i re-pulsed while busy -> ignored (exactly 10 records). AUTO_REARM=1, run_i=1 -> comm_o[24]=1 the cycle after done_o.

Source files
------------

// File: rtl/cache_stats_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_stats_reader_if
//  Brief    : Host-side and controller-side signals of one stats reader.
//  Revision : 1.0 - initial release
// ============================================================================
interface cache_stats_reader_if;
    logic        run;
    logic        start;
    logic [31:0] comm_cmd;
    logic [1:0]  select_data_record;
    logic [31:0] comm_rdata;
    logic [63:0] data;
    logic [3:0]  index;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;

    modport master (
        input  run, start, comm_rdata, ready,
        output comm_cmd, select_data_record, data, index, valid, busy, done
    );

    modport slave (
        output run, start, comm_rdata, ready,
        input  comm_cmd, select_data_record, data, index, valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/cache_stats_reader.sv
`default_nettype none
// ============================================================================
//  Module   : cache_stats_reader
//  Brief    : Freezes a cache performance controller, reads its ten 64-bit
//             statistics as 32-bit word pairs and streams {index, value}.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_stats_reader #(
    parameter int READ_LATENCY = 2,
    parameter bit AUTO_REARM   = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cache_stats_reader_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FREEZE = 3'd1,
        RD_LO  = 3'd2,
        RD_HI  = 3'd3,
        OUT    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [3:0] c_LAST_INDEX = 4'd9;
    localparam logic [3:0] c_WAIT_LAST  = 4'(READ_LATENCY);
    localparam logic [4:0] c_ID_SELECT  = 5'd15;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_index;
    logic [3:0]  r_wait;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [4:0]  r_sel;
    logic        r_count_en;
    logic        r_armed;

    logic        w_wait_hit;
    logic        w_last;
    logic        w_armed_ok;

    // Low-word select of each record; the high word always sits at +1.
    function automatic logic [4:0] f_lo_sel(input logic [3:0] idx);
        logic [4:0] sel;
        if (idx == c_LAST_INDEX)
            sel = c_ID_SELECT;
        else if (idx >= 4'd7)
            sel = {idx, 1'b0} + 5'd2;
        else
            sel = {idx, 1'b0};
        return sel;
    endfunction

    assign w_wait_hit = (r_wait == c_WAIT_LAST);
    assign w_last     = (r_index == c_LAST_INDEX);
    // Without auto re-arm, leaving DONE must not re-enable counting until run toggles.
    assign w_armed_ok = r_armed && !((r_state == DONE) && (AUTO_REARM == 1'b0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = FREEZE;
            FREEZE:  w_state_nxt = RD_LO;
            RD_LO:   if (w_wait_hit) w_state_nxt = w_last ? OUT : RD_HI;
            RD_HI:   if (w_wait_hit) w_state_nxt = OUT;
            OUT:     if (bus.ready) w_state_nxt = w_last ? DONE : RD_LO;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index    <= 4'd0;
            r_wait     <= 4'd0;
            r_lo       <= 32'd0;
            r_hi       <= 32'd0;
            r_sel      <= 5'd0;
            r_count_en <= 1'b0;
            r_armed    <= 1'b1;
        end else begin
            if ((r_state == RD_LO || r_state == RD_HI) && !w_wait_hit)
                r_wait <= r_wait + 4'd1;
            else
                r_wait <= 4'd0;

            if (r_state == FREEZE)
                r_index <= 4'd0;
            else if (r_state == OUT && bus.ready && !w_last)
                r_index <= r_index + 4'd1;

            if (r_state == RD_LO && w_wait_hit) begin
                r_lo <= bus.comm_rdata;
                if (w_last)
                    r_hi <= 32'd0;
            end
            if (r_state == RD_HI && w_wait_hit)
                r_hi <= bus.comm_rdata;

            if (r_state == FREEZE)
                r_sel <= f_lo_sel(4'd0);
            else if (r_state == RD_LO && w_wait_hit && !w_last)
                r_sel <= f_lo_sel(r_index) + 5'd1;
            else if (r_state == OUT && bus.ready && !w_last)
                r_sel <= f_lo_sel(r_index + 4'd1);

            if (r_state == DONE && AUTO_REARM == 1'b0)
                r_armed <= 1'b0;
            else if (!bus.run)
                r_armed <= 1'b1;

            // Tracks run only in cycles that will be IDLE, so start wins over run.
            r_count_en <= (w_state_nxt == IDLE) && bus.run && w_armed_ok;
        end
    end

    assign bus.comm_cmd           = {7'd0, r_count_en, 19'd0, r_sel};
    assign bus.select_data_record = 2'b00;
    assign bus.data               = {r_hi, r_lo};
    assign bus.index              = r_index;
    assign bus.valid              = (r_state == OUT);
    assign bus.busy               = (r_state != IDLE);
    assign bus.done               = (r_state == DONE);

endmodule
`default_nettype wire
